// File: rtl/ad_sample.sv
// ---------------------------------------------------------------------------
// ad_sample -- frame-based ADC sampler.
//
// Captures N_SAMPLES codes from a 10-bit offset-binary ADC at a rate selected
// by key_value. Each captured code is presented as a two's-complement sample
// with its index. The frame maximum, minimum and peak-to-peak of the raw codes
// are published when the frame completes.
//
// Ports
//   clk_6_4m    in   1      sole clock, 6.4 MHz
//   rst_n       in   1      asynchronous active-low reset
//   ad_data     in   10     ADC code, offset binary, asynchronous
//   key_value   in   1      rate select (0: DIV_FAST, 1: DIV_SLOW), asynchronous
//   start       in   1      single-cycle frame capture request
//   busy        out  1      high while a frame is in progress
//   samp_valid  out  1      strobe qualifying samp_data / samp_index
//   samp_data   out  10     two's-complement sample
//   samp_index  out  IDX_W  sample index within the frame
//   frame_done  out  1      pulse after the last sample of a frame
//   ad_max      out  10     frame maximum (raw code)
//   ad_min      out  10     frame minimum (raw code)
//   ad_pp       out  10     ad_max - ad_min
// ---------------------------------------------------------------------------
module ad_sample #(
  parameter int N_SAMPLES = 1024,
  parameter int DIV_FAST  = 10,
  parameter int DIV_SLOW  = 25,
  localparam int IDX_W    = (N_SAMPLES > 1) ? $clog2(N_SAMPLES) : 1
) (
  input  logic             clk_6_4m,
  input  logic             rst_n,
  input  logic [9:0]       ad_data,
  input  logic             key_value,
  input  logic             start,
  output logic             busy,
  output logic             samp_valid,
  output logic [9:0]       samp_data,
  output logic [IDX_W-1:0] samp_index,
  output logic             frame_done,
  output logic [9:0]       ad_max,
  output logic [9:0]       ad_min,
  output logic [9:0]       ad_pp
);

  localparam int DIV_MAX = (DIV_SLOW > DIV_FAST) ? DIV_SLOW : DIV_FAST;
  localparam int CNT_W   = (DIV_MAX > 1) ? $clog2(DIV_MAX) : 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    DONE    = 2'd2
  } state_t;

  // Offset binary to two's complement: flipping the MSB subtracts 512.
  function automatic logic [9:0] to_twos(input logic [9:0] code);
    return {~code[9], code[8:0]};
  endfunction

  state_t             state_q;
  logic [9:0]         ad_reg_q;
  logic               key_meta_q;
  logic               key_sync_q;
  logic               rate_sel_q;
  logic [CNT_W-1:0]   div_cnt_q;
  logic [IDX_W-1:0]   samp_cnt_q;
  logic [9:0]         run_max_q;
  logic [9:0]         run_min_q;
  logic               busy_q;
  logic               samp_valid_q;
  logic [9:0]         samp_data_q;
  logic [IDX_W-1:0]   samp_index_q;
  logic               frame_done_q;
  logic [9:0]         ad_max_q;
  logic [9:0]         ad_min_q;
  logic [9:0]         ad_pp_q;

  logic [CNT_W-1:0]   div_last_s;
  logic               last_samp_s;
  logic [9:0]         run_max_d;
  logic [9:0]         run_min_d;

  // Divider terminal count, last-sample flag and running extremes including ad_reg_q.
  always_comb begin
    div_last_s  = rate_sel_q ? CNT_W'(DIV_SLOW - 1) : CNT_W'(DIV_FAST - 1);
    last_samp_s = (samp_cnt_q == IDX_W'(N_SAMPLES - 1));
    // Strict compares: a sample equal to the current extreme leaves it as is.
    if (ad_reg_q > run_max_q) begin
      run_max_d = ad_reg_q;
    end else begin
      run_max_d = run_max_q;
    end
    if (ad_reg_q < run_min_q) begin
      run_min_d = ad_reg_q;
    end else begin
      run_min_d = run_min_q;
    end
  end

  // Input registers, key synchronizer, capture FSM and all registered outputs.
  always_ff @(posedge clk_6_4m or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      ad_reg_q     <= 10'd0;
      key_meta_q   <= 1'b0;
      key_sync_q   <= 1'b0;
      rate_sel_q   <= 1'b0;
      div_cnt_q    <= '0;
      samp_cnt_q   <= '0;
      run_max_q    <= 10'd0;
      run_min_q    <= 10'h3FF;
      busy_q       <= 1'b0;
      samp_valid_q <= 1'b0;
      samp_data_q  <= 10'd0;
      samp_index_q <= '0;
      frame_done_q <= 1'b0;
      ad_max_q     <= 10'd0;
      ad_min_q     <= 10'h3FF;
      ad_pp_q      <= 10'd0;
    end else begin
      ad_reg_q     <= ad_data;
      key_meta_q   <= key_value;
      key_sync_q   <= key_meta_q;
      samp_valid_q <= 1'b0;
      frame_done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            // Rate is frozen for the whole frame at acceptance.
            rate_sel_q <= key_sync_q;
            div_cnt_q  <= '0;
            samp_cnt_q <= '0;
            run_max_q  <= 10'd0;
            run_min_q  <= 10'h3FF;
            busy_q     <= 1'b1;
            state_q    <= CAPTURE;
          end else begin
            busy_q     <= 1'b0;
          end
        end
        CAPTURE: begin
          if (div_cnt_q == div_last_s) begin
            div_cnt_q    <= '0;
            samp_valid_q <= 1'b1;
            samp_data_q  <= to_twos(ad_reg_q);
            samp_index_q <= samp_cnt_q;
            run_max_q    <= run_max_d;
            run_min_q    <= run_min_d;
            if (last_samp_s) begin
              state_q    <= DONE;
            end else begin
              samp_cnt_q <= samp_cnt_q + IDX_W'(1);
            end
          end else begin
            div_cnt_q    <= div_cnt_q + CNT_W'(1);
          end
        end
        DONE: begin
          // Running extremes already include the last sample here.
          frame_done_q <= 1'b1;
          ad_max_q     <= run_max_q;
          ad_min_q     <= run_min_q;
          ad_pp_q      <= run_max_q - run_min_q;
          busy_q       <= 1'b0;
          state_q      <= IDLE;
        end
        default: begin
          busy_q       <= 1'b0;
          state_q      <= IDLE;
        end
      endcase
    end
  end

  assign busy       = busy_q;
  assign samp_valid = samp_valid_q;
  assign samp_data  = samp_data_q;
  assign samp_index = samp_index_q;
  assign frame_done = frame_done_q;
  assign ad_max     = ad_max_q;
  assign ad_min     = ad_min_q;
  assign ad_pp      = ad_pp_q;

endmodule

// File: tb/tb_ad_sample.sv
// ---------------------------------------------------------------------------
// tb_ad_sample -- scoreboard bench for ad_sample.
// A reference model derives, from the cycle a start is accepted, when every
// sample strobe and the frame_done pulse must appear and with which values,
// and queues them. A monitor on the falling edge compares every cycle.
// ---------------------------------------------------------------------------
module tb_ad_sample;

  localparam int N  = 1024;
  localparam int DF = 10;
  localparam int DS = 25;

  logic       clk_6_4m = 1'b0;
  logic       rst_n    = 1'b0;
  logic [9:0] ad_data;
  logic       key_value = 1'b0;
  logic       start     = 1'b0;
  logic       busy;
  logic       samp_valid;
  logic [9:0] samp_data;
  logic [9:0] samp_index;
  logic       frame_done;
  logic [9:0] ad_max;
  logic [9:0] ad_min;
  logic [9:0] ad_pp;

  ad_sample #(.N_SAMPLES(N), .DIV_FAST(DF), .DIV_SLOW(DS)) dut (
    .clk_6_4m  (clk_6_4m),
    .rst_n     (rst_n),
    .ad_data   (ad_data),
    .key_value (key_value),
    .start     (start),
    .busy      (busy),
    .samp_valid(samp_valid),
    .samp_data (samp_data),
    .samp_index(samp_index),
    .frame_done(frame_done),
    .ad_max    (ad_max),
    .ad_min    (ad_min),
    .ad_pp     (ad_pp)
  );

  always #78 clk_6_4m = ~clk_6_4m;

  typedef struct { int due; int idx; logic [9:0] data; } samp_t;
  typedef struct { int due; logic [9:0] mx; logic [9:0] mn; logic [9:0] pp; } done_t;

  samp_t samp_q[$];
  done_t done_q[$];
  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Reference model state
  bit   in_frame = 1'b0;
  int   s_cyc, div, busy_end, fmax, fmin, off;
  logic k1 = 1'b0, k2 = 1'b0;   // key_value at the previous two edges
  samp_t se;
  done_t de;

  // ADC stimulus: 0 constant, 1 ramp (~32 MHz steps), 2 random per cycle
  int         drive_mode = 0;
  logic [9:0] const_val  = 10'd0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_busy"},       busy,       0);
    chk({tag, "_samp_valid"}, samp_valid, 0);
    chk({tag, "_frame_done"}, frame_done, 0);
    chk({tag, "_samp_data"},  samp_data,  0);
    chk({tag, "_samp_index"}, samp_index, 0);
    chk({tag, "_ad_max"},     ad_max,     0);
    chk({tag, "_ad_min"},     ad_min,     32'h3FF);
    chk({tag, "_ad_pp"},      ad_pp,      0);
  endtask

  // ADC driver: changes happen away from the rising edge.
  always @(posedge clk_6_4m) begin
    if (drive_mode == 1) begin
      for (int i = 0; i < 5; i++) begin
        #(i == 0 ? 5 : 30);
        ad_data = ad_data + 10'd1;
      end
    end else if (drive_mode == 2) begin
      #40 ad_data = 10'($urandom_range(0, 1023));
    end else begin
      #40 ad_data = const_val;
    end
  end

  // Reference model: a frame accepted at edge s takes sample k (1..N) from the
  // ADC code present at edge s+k*div-1, strobes it after edge s+k*div, and
  // pulses frame_done after edge s+N*div+1 when the block returns to idle.
  always @(posedge clk_6_4m or negedge rst_n) begin
    if (!rst_n) begin
      in_frame = 1'b0;
      samp_q.delete();
      done_q.delete();
      k1 = 1'b0;
      k2 = 1'b0;
    end else begin
      cyc++;
      if (in_frame) begin
        off = cyc - s_cyc;
        if ((off % div) == div - 1 && off < N * div) begin
          se.due  = cyc + 1;
          se.idx  = off / div;
          se.data = 10'(int'(ad_data) - 512);
          samp_q.push_back(se);
          if (int'(ad_data) > fmax) fmax = int'(ad_data);
          if (int'(ad_data) < fmin) fmin = int'(ad_data);
          if (se.idx == N - 1) begin
            de.due = cyc + 2;
            de.mx  = 10'(fmax);
            de.mn  = 10'(fmin);
            de.pp  = 10'(fmax - fmin);
            done_q.push_back(de);
          end
        end
        if (cyc == busy_end) in_frame = 1'b0;
      end else if (start) begin
        in_frame = 1'b1;
        s_cyc    = cyc;
        div      = k2 ? DS : DF;
        busy_end = cyc + N * div + 1;
        fmax     = 0;
        fmin     = 1023;
      end
      k2 = k1;
      k1 = key_value;
    end
  end

  // Monitor: every cycle, compare strobes, payloads and busy with the model.
  always @(negedge clk_6_4m) begin
    if (rst_n) begin
      if (samp_q.size() > 0 && samp_q[0].due == cyc) begin
        se = samp_q.pop_front();
        chk("samp_valid", samp_valid, 1);
        if (samp_valid) begin
          chk("samp_data",  samp_data,  se.data);
          chk("samp_index", samp_index, se.idx);
        end
      end else begin
        chk("samp_valid_idle", samp_valid, 0);
      end
      if (done_q.size() > 0 && done_q[0].due == cyc) begin
        de = done_q.pop_front();
        chk("frame_done", frame_done, 1);
        chk("ad_max", ad_max, de.mx);
        chk("ad_min", ad_min, de.mn);
        chk("ad_pp",  ad_pp,  de.pp);
      end else begin
        chk("frame_done_idle", frame_done, 0);
      end
      chk("busy", busy, in_frame);
    end
  end

  task automatic pulse_start();
    @(negedge clk_6_4m);
    start = 1'b1;
    @(negedge clk_6_4m);
    start = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (in_frame && n < budget) begin
      @(negedge clk_6_4m);
      n++;
    end
    checks++;
    if (in_frame) begin
      errors++;
      $display("FAIL frame_timeout actual=busy expected=idle within %0d cycles", budget);
    end
    repeat ($urandom_range(3, 12)) @(negedge clk_6_4m);
  endtask

  initial begin
    // Reset held for 1000 ns
    #990;
    check_reset_vals("reset");
    #10 rst_n = 1'b1;
    repeat (100) @(negedge clk_6_4m);
    check_reset_vals("post_reset_idle");

    // Fast rate, full-scale constant
    const_val = 10'h3FF;
    key_value = 1'b0;
    pulse_start();
    wait_idle(30000);

    // Slow rate, zero constant
    key_value = 1'b1;
    const_val = 10'h000;
    repeat (5) @(negedge clk_6_4m);
    pulse_start();
    wait_idle(30000);

    // Fast rate, ramp; second start and key toggle mid-frame are ignored
    key_value  = 1'b0;
    drive_mode = 1;
    repeat (5) @(negedge clk_6_4m);
    pulse_start();
    repeat (50) @(negedge clk_6_4m);
    key_value = 1'b1;
    start     = 1'b1;
    @(negedge clk_6_4m);
    start     = 1'b0;
    wait_idle(30000);
    key_value = 1'b0;
    repeat (5) @(negedge clk_6_4m);

    // Random data, reset around sample 500, then a fresh full frame
    drive_mode = 2;
    pulse_start();
    repeat (500 * DF) @(negedge clk_6_4m);
    #10 rst_n = 1'b0;
    #1;
    chk("abort_busy", busy, 0);
    check_reset_vals("abort");
    @(negedge clk_6_4m);
    #10 rst_n = 1'b1;
    repeat (20) @(negedge clk_6_4m);
    pulse_start();
    wait_idle(30000);

    repeat (5) @(negedge clk_6_4m);
    chk("samp_queue_drained", samp_q.size(), 0);
    chk("done_queue_drained", done_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ad_sample.md
AD_SAMPLE -- requirements
Module: ad_sample

Interface
REQ-001 SHALL have parameter N_SAMPLES, default 1024: samples per frame.
REQ-002 SHALL have parameter DIV_FAST, default 10: clk_6_4m cycles per sample for the 640 kHz rate.
REQ-003 SHALL have parameter DIV_SLOW, default 25: clk_6_4m cycles per sample for the 256 kHz rate.
REQ-004 clk_6_4m  input  1  sole clock, 6.4 MHz.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 ad_data  input  10  ADC code, offset binary, asynchronous to clk_6_4m.
REQ-007 key_value  input  1  rate select: 0 = 640 kHz (DIV_FAST), 1 = 256 kHz (DIV_SLOW).
REQ-008 start  input  1  single-cycle frame capture request.
REQ-009 busy  output  1  high while a frame is being captured.
REQ-010 samp_valid  output  1  single-cycle strobe qualifying samp_data and samp_index.
REQ-011 samp_data  output  10  two's-complement sample, {~ad[9], ad[8:0]}.
REQ-012 samp_index  output  log2(N_SAMPLES)  sample index within the frame, 0..N_SAMPLES-1.
REQ-013 frame_done  output  1  single-cycle pulse after the last sample of a frame.
REQ-014 ad_max, ad_min  output  10 each  frame maximum and minimum, raw unsigned codes.
REQ-015 ad_pp  output  10  ad_max minus ad_min.

Function
REQ-016 ad_data SHALL be registered into ad_reg on every clk_6_4m edge; samples SHALL be taken from ad_reg.
REQ-017 key_value SHALL pass through a 2-flop synchronizer; the synchronized value SHALL be latched as rate_sel only when start is accepted.
REQ-018 The FSM SHALL have three states.
- IDLE: start=1 -> CAPTURE.
- CAPTURE: after sample N_SAMPLES-1 -> DONE.
- DONE: unconditionally -> IDLE after one cycle.
REQ-019 On start acceptance the FSM SHALL:
- clear the divider counter and the sample index;
- set the running max to 0 and the running min to 1023.
REQ-020 In CAPTURE the divider counter SHALL count 0..DIV-1 and wrap; DIV = DIV_SLOW if rate_sel else DIV_FAST.
REQ-021 A sample SHALL be taken in each cycle where the counter equals DIV-1; samp_valid SHALL assert on the next cycle.
REQ-022 The first samp_valid SHALL occur exactly DIV cycles after the start cycle, with consecutive samp_valid exactly DIV cycles apart.
REQ-023 samp_index SHALL be 0 on the first sample of a frame and increment by 1 per sample, with no wrap inside a frame.
REQ-024 The running max and min SHALL update with every sample; a sample equal to the current extreme SHALL leave it unchanged.
REQ-025 On the last sample, ad_max, ad_min and ad_pp SHALL be updated in the same cycle that frame_done asserts; they SHALL then hold until the next frame's frame_done.
REQ-026 frame_done SHALL assert in the cycle after the last samp_valid, i.e. while in DONE.
REQ-027 busy SHALL be 1 in CAPTURE and DONE and 0 in IDLE; start SHALL be ignored while busy=1.
REQ-028 A key_value change during a frame SHALL NOT affect that frame.
REQ-029 samp_valid and frame_done SHALL never be high in the same cycle.

Reset
REQ-030 rst_n low SHALL asynchronously force:
- state IDLE, counter 0, index 0, synchronizer 0, rate_sel 0;
- busy, samp_valid, frame_done = 0;
- samp_data, samp_index, ad_pp = 0;
- ad_max = 0, ad_min = 0x3FF.
REQ-031 Reset asserted mid-frame SHALL abort the frame with no frame_done; after release the block SHALL sit in IDLE awaiting start.
REQ-032 Outputs SHALL be driven from registers only.

Verification
REQ-033 Reset: hold rst_n=0 for 1000 ns -> all outputs at REQ-030 values; no samp_valid for 100 cycles after release without start.
REQ-034 key_value=0, ad_data=0x3FF constant, start pulse -> first samp_valid 10 cycles after start, samp_data=0x1FF; 1024 strobes 10 cycles apart; frame_done at cycle 10241 after start; ad_pp=0.
REQ-035 key_value=1, ad_data=0x000 -> samp_data=0x200 (-512) and strobes 25 cycles apart; frame_done at cycle 25601 after start.
REQ-036 ad_data ramping 0..1023 and wrapping at 32 MHz -> after frame_done ad_max and ad_min bracket all captured codes, and ad_pp = ad_max - ad_min.
REQ-037 Second start 50 cycles into a frame, plus a key_value toggle -> ignored; the frame keeps DIV=10 and 1024 samples.
REQ-038 rst_n pulsed low at sample 500 -> busy=0 immediately, no frame_done, and a new start yields a full 1024-sample frame from index 0.
